// File: rtl/instr_fetch_sequencer_if.sv
// Fetch-sequencer bus: ROM address/data, execute-side valid/ready slot, branch redirect and wait status.
// master = sequencer side, slave = ROM/execute side.
interface instr_fetch_sequencer_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 28
);
  logic [ADDR_W-1:0]  oRomAddress;
  logic [INSTR_W-1:0] iRomInstruction;
  logic [INSTR_W-1:0] oInstruction;
  logic [ADDR_W-1:0]  oPC;
  logic               oInstrValid;
  logic               iInstrReady;
  logic               iBranchTaken;
  logic [ADDR_W-1:0]  iBranchTarget;
  logic               oBusy;

  modport master (
    output oRomAddress, oInstruction, oPC, oInstrValid, oBusy,
    input  iRomInstruction, iInstrReady, iBranchTaken, iBranchTarget
  );

  modport slave (
    input  oRomAddress, oInstruction, oPC, oInstrValid, oBusy,
    output iRomInstruction, iInstrReady, iBranchTaken, iBranchTarget
  );
endinterface

// File: rtl/instr_fetch_sequencer.sv
// Owns the PC, registers each ROM word into a valid/ready slot for execute, redirects on taken branches.
// NOP-operand wait periods (RUN/WAIT FSM, 24-bit counter) are built only with INSTR_FETCH_NOP_DELAY_EN defined.
`ifndef NOP
`define NOP 4'h0
`endif

module instr_fetch_sequencer #(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 28,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic                      Clock,
  input logic                      Reset,
  instr_fetch_sequencer_if.master  bus
);
  logic [ADDR_W-1:0]  fetch_pc;
  logic [ADDR_W-1:0]  pc_q;
  logic [INSTR_W-1:0] instr_q;
  logic               vld_q;
  logic               accept;
  logic               load;
  logic               hold_vld;
  logic               release_wait;
  logic               busy;

  assign accept = vld_q & bus.iInstrReady;

`ifdef INSTR_FETCH_NOP_DELAY_EN
  localparam logic [3:0] NOP_OP = `NOP;

  typedef enum logic {ST_RUN, ST_WAIT} state_t;
  state_t      state;
  state_t      state_nxt;
  logic [23:0] wait_cnt;
  logic        nop_hit;

  // Only a slot that execute is taking right now can start a wait.
  assign nop_hit = accept && (instr_q[INSTR_W-1 -: 4] == NOP_OP) && (instr_q[23:0] != 24'd0);

  always_ff @(posedge Clock) begin
    if (Reset) state <= ST_RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.iBranchTaken) begin
      state_nxt = ST_RUN;
    end else begin
      case (state)
        ST_RUN:  if (nop_hit) state_nxt = ST_WAIT;
        ST_WAIT: if (wait_cnt == 24'd1) state_nxt = ST_RUN;
        default: state_nxt = ST_RUN;
      endcase
    end
  end

  always_comb begin
    load         = 1'b0;
    hold_vld     = 1'b0;
    release_wait = 1'b0;
    busy         = (state == ST_WAIT);
    if (!bus.iBranchTaken) begin
      if (state == ST_RUN) begin
        load     = !vld_q || bus.iInstrReady;
        hold_vld = nop_hit;
      end else begin
        release_wait = (wait_cnt == 24'd1);
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset || bus.iBranchTaken)        wait_cnt <= '0;
    else if (state == ST_RUN && nop_hit)  wait_cnt <= instr_q[23:0];
    else if (state == ST_WAIT)            wait_cnt <= wait_cnt - 24'd1;
  end
`else
  always_comb begin
    load         = !bus.iBranchTaken && (!vld_q || bus.iInstrReady);
    hold_vld     = 1'b0;
    release_wait = 1'b0;
    busy         = 1'b0;
  end
`endif

  // Branch beats everything: the slot is flushed and the target fetched on the following edge.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      fetch_pc <= RESET_PC;
      pc_q     <= '0;
      instr_q  <= '0;
      vld_q    <= 1'b0;
    end else if (bus.iBranchTaken) begin
      fetch_pc <= bus.iBranchTarget;
      vld_q    <= 1'b0;
    end else if (load) begin
      instr_q  <= bus.iRomInstruction;
      pc_q     <= fetch_pc;
      vld_q    <= !hold_vld;
      fetch_pc <= fetch_pc + ADDR_W'(1);
    end else if (release_wait) begin
      vld_q    <= 1'b1;
    end
  end

  assign bus.oRomAddress  = fetch_pc;
  assign bus.oInstruction = instr_q;
  assign bus.oPC          = pc_q;
  assign bus.oInstrValid  = vld_q;
  assign bus.oBusy        = busy;
endmodule

// File: doc/instr_fetch_sequencer.md
# instr_fetch_sequencer

Program-sequencing controller between the instruction ROM and the execute stage of the lab processor. It owns the program counter and drives the ROM address. It registers each fetched 28-bit instruction and presents it to execute through a valid/ready handshake. It redirects on taken branches and jumps, and it can turn `NOP` operands into timed wait periods.

## Interface
- `ADDR_W`, 16: program-counter / ROM address width.
- `INSTR_W`, 28: instruction width; opcode field is `[27:24]`, operand field is `[23:0]`.
- `RESET_PC`, 0: first address fetched after reset.

- `Clock`  in  1  single clock; all state updates on rising edge.
- `Reset`  in  1  synchronous, active-high.
- `oRomAddress`  out  ADDR_W  ROM address; driven straight from the fetch-PC register (no combinational path from inputs).
- `iRomInstruction`  in  INSTR_W  ROM data; combinational, same-cycle response to `oRomAddress`.
- `oInstruction`  out  INSTR_W  registered instruction presented to execute.
- `oPC`  out  ADDR_W  address of `oInstruction`.
- `oInstrValid`  out  1  `oInstruction`/`oPC` are valid.
- `iInstrReady`  in  1  execute accepts; transfer when `oInstrValid & iInstrReady`.
- `iBranchTaken`  in  1  redirect request (taken `BLE`, `JMP`).
- `iBranchTarget`  in  ADDR_W  redirect address.
- `oBusy`  out  1  high while a NOP wait period is active.

## Operation
- **Reset values:**
  - fetch PC = `RESET_PC`; `oInstruction` = 0; `oPC` = 0.
  - `oInstrValid` = 0; `oBusy` = 0; wait counter = 0; state = `RUN`.
- **States:** `RUN` and `WAIT`.
- **RUN, load:** when the output slot is empty or being accepted, and there is no branch, the next edge does all of:
  - `oInstruction` ← `iRomInstruction`
  - `oPC` ← fetch PC
  - `oInstrValid` ← 1
  - fetch PC ← fetch PC + 1
- **RUN, stall:** `oInstrValid=1`, `iInstrReady=0`, no branch. `oInstruction`, `oPC`, `oInstrValid` and the fetch PC all hold.
- **Branch:** `iBranchTaken=1` in any state. At the next edge:
  - fetch PC ← `iBranchTarget`; `oInstrValid` ← 0 (slot flushed).
  - Any `WAIT` is aborted: counter cleared, `oBusy` ← 0, state ← `RUN`.
  - Branch has priority over accept, load and wait.
- **NOP wait** (only with the macro, see Configuration):
  - Trigger: an accepted instruction whose opcode equals `` `NOP `` from `Defintions.v`, with operand N = `[23:0]` and N > 0.
  - `WAIT` is entered at the acceptance edge.
  - The following instruction is loaded at that edge as usual, but `oInstrValid` is forced to 0.
  - `WAIT` returns to `RUN` after N cycles.
  - N = 0 causes no wait.
- **Arithmetic:**
  - Fetch PC is modulo 2^ADDR_W: 0xFFFF+1 → 0x0000 with no flag.
  - Wait counter is 24 bits unsigned, so the maximum wait is 16,777,215 cycles.
- **Reset mid-operation:** `Reset` overrides everything in the same edge, including an active `WAIT` or a pending branch.

## Timing
- **Reset release:** first instruction (address `RESET_PC`) has `oInstrValid=1` at the first edge after `Reset` falls. One cycle of latency.
- **Throughput:** one instruction per cycle with `iInstrReady` held high.
- **Branch penalty:** exactly one invalid cycle. Request at edge E, `oInstrValid=0` during E..E+1, target instruction valid from edge E+1 onward.
- **NOP wait, cycle count:** NOP accepted at edge E0 with operand N; `oInstrValid=0` and `oBusy=1` for cycles E0..E0+N.
- **NOP wait, release:** the held next instruction goes valid at edge E0+N, with `oBusy` falling at the same edge.
- **Output stability:** `oInstruction` and `oPC` never change while `oInstrValid=1 & iInstrReady=0`.

## Configuration
- Macro: `INSTR_FETCH_NOP_DELAY_EN`.
- **Defined:** NOP wait behaviour as specified above; `oBusy` functional.
- **Undefined:**
  - `NOP` is treated like any other instruction; no `WAIT` state and no wait counter are built.
  - `oBusy` is tied to 0.
  - All other behaviour is identical.

## Test plan
- **Reset, stream:** `RESET_PC=0`, `Reset` high 3 cycles then low, `iInstrReady=1`. Required: `oPC` = 0,1,2,3 on consecutive cycles, `oInstrValid` high from the first edge after release, each `oInstruction` equal to the ROM word at its `oPC`.
- **Backpressure:** `iInstrReady=0` for 4 cycles while `oPC=5`. Required: `oPC=5` and `oInstruction` held; `oRomAddress=6` held; resume at 6 when ready returns.
- **Branch:** accept `oPC=11` with `iBranchTaken=1`, `iBranchTarget=5`. Required: one cycle `oInstrValid=0`, then `oPC=5` valid; simultaneous accept ignored.
- **NOP wait (macro on):** accept NOP with operand 4000. Required: `oBusy=1` and `oInstrValid=0` for exactly 4000 cycles, next instruction `oPC`=NOP address+1. Repeat with operand 0: no bubble.
- **Branch and reset abort wait:**
  - Branch during `WAIT` with target 2: `WAIT` aborted, `oBusy=0` next cycle, `oPC=2` one cycle later.
  - `Reset` asserted mid-`WAIT`: all outputs return to reset values next edge.
- **Wrap and macro off:**
  - Set fetch PC to 0xFFFF via branch: next `oPC` values are 0xFFFF, 0x0000.
  - Macro undefined: NOP 4000 passes with zero bubbles and `oBusy` stays 0.
